// File: rtl/pingpong_buffer_ctrl.sv
// Double-buffered input buffer controller for the bf16 multiplier tree.
// Host beats (IN_W) are written into one of two BRAM banks while the other
// bank is streamed out as OUT_W slices, MS slice first. A tracker reports the
// maximum bf16 exponent per node of tree results.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   in_data/in_vld/in_ready   host beat input (accept on in_vld && in_ready)
//   frame_len_minusone        beats per frame - 1, latched on first beat
//   out_data/out_vld          registered slice stream to the tree
//   res_data/res_vld          bf16 results from the tree
//   lines_per_node_minusone   results per node - 1, latched when cnt == 0
//   max_exp/max_exp_vld       registered per-node max exponent and pulse
//   bank_full, wr_bank, rd_bank  bank status
module pingpong_buffer_ctrl #(
   parameter int unsigned IN_W   = 256,
   parameter int unsigned OUT_W  = 128,
   parameter int unsigned RATIO  = 2,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_vld,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] frame_len_minusone,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_vld,
   input  logic [15:0]       res_data,
   input  logic              res_vld,
   input  logic [CNT_W-1:0]  lines_per_node_minusone,
   output logic [7:0]        max_exp,
   output logic              max_exp_vld,
   output logic [1:0]        bank_full,
   output logic              wr_bank,
   output logic              rd_bank
);

   localparam int unsigned PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned DR_W = $clog2(RATIO + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   // Storage: both banks in one array, bank select is the address MSB
   logic [IN_W-1:0]   r_mem [0:2*DEPTH-1];
   logic [IN_W-1:0]   r_rd_data;

   // Writer state
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_wr_bank;
   logic [ADDR_W-1:0] r_len [0:1];
   logic [1:0]        r_bank_full;

   // Reader state
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_bank;
   logic [PH_W-1:0]   r_phase;
   logic [DR_W-1:0]   r_drain;
   logic              r_rd_vld;
   logic [IN_W-1:0]   r_sr;
   logic [PH_W-1:0]   r_rem;
   logic [OUT_W-1:0]  r_out_data;
   logic              r_out_vld;

   // Tracker state
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_lpn;
   logic [7:0]        r_acc;
   logic [7:0]        r_max_exp;
   logic              r_max_exp_vld;

   logic              w_wr_acc;
   logic              w_wr_last;
   logic [ADDR_W-1:0] w_wr_len;
   logic [1:0]        w_set_mask;
   logic [1:0]        w_clr_mask;

   logic [1:0]        w_state_nxt;
   logic              w_issue;
   logic [ADDR_W-1:0] w_rd_len;
   logic [ADDR_W-1:0] w_rd_addr_nxt;
   logic [PH_W-1:0]   w_phase_inc;
   logic [PH_W-1:0]   w_phase_nxt;
   logic [DR_W-1:0]   w_drain_nxt;
   logic              w_release;

   logic [7:0]        w_exp;
   logic [7:0]        w_max;
   logic [CNT_W-1:0]  w_lpn;
   logic              w_unused_res;

   // Writer: the length of the current frame is the live input on its first beat
   assign in_ready   = ~r_bank_full[r_wr_bank];
   assign w_wr_acc   = in_vld & in_ready;
   assign w_wr_len   = (r_wr_addr == '0) ? frame_len_minusone : r_len[r_wr_bank];
   assign w_wr_last  = w_wr_acc & (r_wr_addr == w_wr_len);
   assign w_set_mask = {w_wr_last & r_wr_bank, w_wr_last & ~r_wr_bank};
   assign w_clr_mask = {w_release & r_rd_bank, w_release & ~r_rd_bank};

   // BRAM: one write port, one 1-cycle-latency read port
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[{r_wr_bank, r_wr_addr}] <= in_data;
      end
      if (w_issue) begin
         r_rd_data <= r_mem[{r_rd_bank, r_rd_addr}];
      end
   end

   // Writer registers and shared full flags (set and clear target different banks)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_addr   <= '0;
         r_wr_bank   <= 1'b0;
         r_len[0]    <= '0;
         r_len[1]    <= '0;
         r_bank_full <= 2'b00;
      end else begin
         if (w_wr_acc) begin
            if (r_wr_addr == '0) begin
               r_len[r_wr_bank] <= frame_len_minusone;
            end
            if (w_wr_last) begin
               r_wr_addr <= '0;
               r_wr_bank <= ~r_wr_bank;
            end else begin
               r_wr_addr <= ADDR_W'(r_wr_addr + 1'b1);
            end
         end
         r_bank_full <= (r_bank_full & ~w_clr_mask) | w_set_mask;
      end
   end

   // Reader FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // One word read every RATIO cycles keeps the slice stream gapless
   assign w_rd_len    = r_len[r_rd_bank];
   assign w_phase_inc = (RATIO == 1) ? '0 : PH_W'(r_phase + 1'b1);
   assign w_issue     = ((r_state == S_IDLE) & r_bank_full[r_rd_bank]) |
                        ((r_state == S_STREAM) & (r_phase == '0));

   // Reader FSM next state; DRAIN waits out the slices still in the pipeline
   always_comb begin
      w_state_nxt   = r_state;
      w_rd_addr_nxt = r_rd_addr;
      w_phase_nxt   = r_phase;
      w_drain_nxt   = r_drain;
      w_release     = 1'b0;
      case (r_state)
         S_IDLE, S_STREAM: begin
            if (r_state == S_STREAM) begin
               w_phase_nxt = w_phase_inc;
            end
            if (w_issue) begin
               w_phase_nxt = w_phase_inc;
               if (r_rd_addr == w_rd_len) begin
                  w_state_nxt   = S_DRAIN;
                  w_rd_addr_nxt = '0;
                  w_phase_nxt   = '0;
                  w_drain_nxt   = DR_W'(RATIO);
               end else begin
                  w_state_nxt   = S_STREAM;
                  w_rd_addr_nxt = ADDR_W'(r_rd_addr + 1'b1);
               end
            end
         end
         S_DRAIN: begin
            if (r_drain == '0) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_drain_nxt = DR_W'(r_drain - 1'b1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Reader datapath: word from BRAM is split into slices, MS slice first
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_addr  <= '0;
         r_rd_bank  <= 1'b0;
         r_phase    <= '0;
         r_drain    <= '0;
         r_rd_vld   <= 1'b0;
         r_sr       <= '0;
         r_rem      <= '0;
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
      end else begin
         r_rd_addr <= w_rd_addr_nxt;
         r_phase   <= w_phase_nxt;
         r_drain   <= w_drain_nxt;
         r_rd_vld  <= w_issue;
         if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
         end
         if (r_rd_vld) begin
            r_out_data <= r_rd_data[IN_W-1 -: OUT_W];
            r_sr       <= r_rd_data << OUT_W;
            r_rem      <= PH_W'(RATIO - 1);
            r_out_vld  <= 1'b1;
         end else if (r_rem != '0) begin
            r_out_data <= r_sr[IN_W-1 -: OUT_W];
            r_sr       <= r_sr << OUT_W;
            r_rem      <= PH_W'(r_rem - 1'b1);
            r_out_vld  <= 1'b1;
         end else begin
            r_out_vld  <= 1'b0;
         end
      end
   end

   // Max-exponent tracker; node length is taken live on the node's first result
   assign w_exp        = res_data[14:7];
   assign w_max        = (r_acc > w_exp) ? r_acc : w_exp;
   assign w_lpn        = (r_cnt == '0) ? lines_per_node_minusone : r_lpn;
   assign w_unused_res = ^{res_data[15], res_data[6:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_lpn         <= '0;
         r_acc         <= '0;
         r_max_exp     <= '0;
         r_max_exp_vld <= 1'b0;
      end else begin
         r_max_exp_vld <= 1'b0;
         if (res_vld) begin
            if (r_cnt == '0) begin
               r_lpn <= lines_per_node_minusone;
            end
            if (r_cnt == w_lpn) begin
               r_max_exp     <= w_max;
               r_max_exp_vld <= 1'b1;
               r_cnt         <= '0;
               r_acc         <= '0;
            end else begin
               r_cnt <= CNT_W'(r_cnt + 1'b1);
               r_acc <= w_max;
            end
         end
      end
   end

   assign out_data    = r_out_data;
   assign out_vld     = r_out_vld;
   assign max_exp     = r_max_exp;
   assign max_exp_vld = r_max_exp_vld;
   assign bank_full   = r_bank_full;
   assign wr_bank     = r_wr_bank;
   assign rd_bank     = r_rd_bank;

endmodule
